shift_ctrl: RTL and testbench



---
 rtl/shift_ctrl_pkg.sv | 23 ++
 rtl/shift_tick_gen.sv | 47 ++++
 rtl/shift_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg
// Shared types and helpers for the serial shift controller.
//   state_t     : controller state (IDLE, SHIFT, PARITY, DONE)
//   STATE_W     : state encoding width
//   ctr_width() : counter width for a count range of n, at least one bit
// Optional feature macro used by the controller: SHIFT_CTRL_PARITY_EN.
package shift_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width needed to hold values 0..n-1; a single bit when n is 1.
    function automatic int ctr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// shift_tick_gen
// Bit-period divider: counts clock cycles while enabled and flags the last
// cycle of each DIV-cycle bit period.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   clear : restart the period from zero (word accepted)
//   en    : count this cycle (a bit is being driven)
//   tick  : high on the final cycle of the current bit period
module shift_tick_gen
    import shift_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              DW       = ctr_width(DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] divcnt_q;
    logic [DW-1:0] divcnt_d;

    assign tick = en && (divcnt_q == DIV_LAST);

    // Wraps to zero on the terminal count so it never runs past DIV-1.
    always_comb begin
        divcnt_d = divcnt_q;
        if (clear) begin
            divcnt_d = '0;
        end else if (en) begin
            divcnt_d = tick ? '0 : divcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divcnt_q <= '0;
        end else begin
            divcnt_q <= divcnt_d;
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl
// Accepts a parallel word over valid/ready and shifts it out MSB-first,
// holding every bit for DIV clock cycles, then pulses done for one cycle.
// One word in flight at a time.
//   clk, reset  : clock, synchronous active-high reset
//   in_data     : parallel word (WIDTH bits)
//   in_valid    : producer offers in_data
//   in_ready    : controller is IDLE and will take a word
//   sout        : serial data, MSB first
//   sout_valid  : sout carries a data (or parity) bit
//   busy        : word in flight
//   done        : one-cycle pulse after the last bit
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on registered state, never on in_valid.
// Optional feature: define SHIFT_CTRL_PARITY_EN to append an even-parity
// bit (^in_data captured at accept) after the LSB, held for DIV cycles.
// state_q is the observable FSM state for checkers.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = ctr_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             in_ready_q, in_ready_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SHIFT_CTRL_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic accept;
    logic tick_en;
    logic tick;

    assign accept  = (state_q == ST_IDLE) && in_valid;
    assign tick_en = (state_q == ST_SHIFT) || (state_q == ST_PARITY);

    shift_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef SHIFT_CTRL_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d  = in_data;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
`ifdef SHIFT_CTRL_PARITY_EN
                    parity_d = ^in_data;
`endif
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (bitcnt_q != BIT_LAST) begin
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_d = bitcnt_q + BW'(1);
                    end else begin
`ifdef SHIFT_CTRL_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so each one lines
    // up with the state it describes, with no path from in_valid.
    always_comb begin
        in_ready_d   = (state_d == ST_IDLE);
        busy_d       = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
        sout_valid_d = busy_d;
        done_d       = (state_d == ST_DONE);
        sout_d       = 1'b0;
        if (state_d == ST_SHIFT) begin
            sout_d = shreg_d[WIDTH-1];
        end
`ifdef SHIFT_CTRL_PARITY_EN
        if (state_d == ST_PARITY) begin
            sout_d = parity_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            in_ready_q   <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            in_ready_q   <= in_ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SHIFT_CTRL_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl
// Drives two controllers (DIV=1 and DIV=3) from shared inputs and compares
// every cycle against a timeline model: a word accepted at cycle 0 has data
// bit k during cycles 1+k*DIV..(k+1)*DIV, optional parity next, then done.
module tb_shift_ctrl;

    localparam int W = 8;
`ifdef SHIFT_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N0 = (W + PAR) * 1;
    localparam int N1 = (W + PAR) * 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic in_ready0, sout0, sout_valid0, busy0, done0;
    logic in_ready1, sout1, sout_valid1, busy1, done1;

    shift_ctrl #(.WIDTH(W), .DIV(1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .sout(sout0), .sout_valid(sout_valid0),
        .busy(busy0), .done(done0)
    );

    shift_ctrl #(.WIDTH(W), .DIV(3)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .sout(sout1), .sout_valid(sout_valid1),
        .busy(busy1), .done(done1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // act: word in flight; t: cycle index since accept (1..N+1).
    bit           act0 = 1'b0, act1 = 1'b0;
    int           t0 = 0, t1 = 0;
    logic [W-1:0] w0 = '0, w1 = '0;

    always @(posedge clk) begin
        if (reset) act0 <= 1'b0;
        else if (act0) begin
            if (t0 == N0 + 1) act0 <= 1'b0;
            else t0 <= t0 + 1;
        end else if (in_valid) begin
            act0 <= 1'b1; t0 <= 1; w0 <= in_data;
        end
    end

    always @(posedge clk) begin
        if (reset) act1 <= 1'b0;
        else if (act1) begin
            if (t1 == N1 + 1) act1 <= 1'b0;
            else t1 <= t1 + 1;
        end else if (in_valid) begin
            act1 <= 1'b1; t1 <= 1; w1 <= in_data;
        end
    end

    // {in_ready, sout, sout_valid, busy, done}
    function automatic logic [4:0] exp_out(input bit act, input int t, input logic [W-1:0] w, input int div);
        if (!act) return 5'b10000;
        if (t <= W * div) return {1'b0, w[W-1-(t-1)/div], 3'b110};
        if (t <= (W + PAR) * div) return {1'b0, ^w, 3'b110};
        return 5'b00001;
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("outs_div1", {in_ready0, sout0, sout_valid0, busy0, done0}, exp_out(act0, t0, w0, 1));
            check("outs_div3", {in_ready1, sout1, sout_valid1, busy1, done1}, exp_out(act1, t1, w1, 3));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (!(in_ready0 && in_ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {63'd0, in_ready0 && in_ready1}, 64'd1);
    endtask

    // Offers w for one cycle once instance inst is ready; records sout per
    // cycle (bit t = cycle t) and the first done / in_ready cycles.
    task automatic run_word(input int inst, input logic [W-1:0] w,
                            output logic [63:0] sbits, output int done_cyc, output int rdy_cyc);
        int n = 0;
        while (!((inst == 0) ? in_ready0 : in_ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("run_word_ready_timeout", {63'd0, (inst == 0) ? in_ready0 : in_ready1}, 64'd1);
        in_data  = w;
        in_valid = 1'b1;
        sbits    = '0;
        done_cyc = -1;
        rdy_cyc  = -1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            sbits[t] = (inst == 0) ? sout0 : sout1;
            if (((inst == 0) ? done0 : done1) && done_cyc < 0) done_cyc = t;
            if (((inst == 0) ? in_ready0 : in_ready1) && rdy_cyc < 0) rdy_cyc = t;
        end
    endtask

    function automatic logic [W-1:0] msb_first(input logic [63:0] sbits);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[W-1-k] = sbits[1+k];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] sb;
        int dc, rc, prev_busy, second_busy, done_cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", {63'd0, in_ready0}, 64'd1);
        check("reset_idle_outs", {60'd0, sout0, sout_valid0, busy0, done0}, 64'd0);

        // A5 at DIV=1
        run_word(0, 8'hA5, sb, dc, rc);
        check("a5_bits", {56'd0, msb_first(sb)}, 64'hA5);
        check("a5_done_cycle", dc, (PAR != 0) ? 64'd10 : 64'd9);
        check("a5_ready_cycle", rc, (PAR != 0) ? 64'd11 : 64'd10);
        check("a5_parity_slot", {63'd0, sb[9]}, 64'd0);

        // 80 at DIV=3
        run_word(1, 8'h80, sb, dc, rc);
        check("h80_first_bit", {61'd0, sb[3:1]}, 64'd7);
        check("h80_rest_zero", {43'd0, sb[24:4]}, 64'd0);
        check("h80_done_cycle", dc, (PAR != 0) ? 64'd28 : 64'd25);
        check("h80_parity_slot", {61'd0, sb[27:25]}, (PAR != 0) ? 64'd7 : 64'd0);

        // 07 at DIV=1: parity bit 1 in cycle 9 when enabled
        run_word(0, 8'h07, sb, dc, rc);
        check("h07_bits", {56'd0, msb_first(sb)}, 64'h07);
        check("h07_cycle9", {63'd0, sb[9]}, (PAR != 0) ? 64'd1 : 64'd0);
        check("h07_done_cycle", dc, (PAR != 0) ? 64'd10 : 64'd9);

        // in_valid held high: 01 then FF, data changing during SHIFT
        wait_idle();
        in_data  = 8'h01;
        in_valid = 1'b1;
        prev_busy   = 0;
        second_busy = -1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            in_data = 8'hFF;
            if (busy0 && !prev_busy && t > 1 && second_busy < 0) second_busy = t;
            prev_busy = busy0;
        end
        in_valid = 1'b0;
        check("second_accept_busy_cycle", second_busy, (PAR != 0) ? 64'd12 : 64'd11);

        // reset in cycle 4 of a word
        wait_idle();
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {62'd0, in_ready0, in_ready1}, 64'd3);
        check("abort_sout_busy", {60'd0, sout0, busy0, sout1, busy1}, 64'd0);
        done_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            done_cnt += int'(done0) + int'(done1);
        end
        check("abort_no_done", done_cnt, 64'd0);
        run_word(0, 8'h3C, sb, dc, rc);
        check("h3c_bits", {56'd0, msb_first(sb)}, 64'h3C);

        // random phase
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            reset    = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
